// File: rtl/vga_timing_gen_if.sv
// Raster control inputs and timed pixel outputs of the VGA timing generator.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 11,
    parameter int unsigned CB = 1
);
    logic          en;
    logic [1:0]    mode;
    logic          hsync_out;
    logic          vsync_out;
    logic          blank_out;
    logic [CB-1:0] red_out;
    logic [CB-1:0] green_out;
    logic [CB-1:0] blue_out;
    logic [CW-1:0] hpos_out;
    logic [CW-1:0] vpos_out;
    logic          line_start;
    logic          frame_start;

    // Generator side
    modport master (
        input  en, mode,
        output hsync_out, vsync_out, blank_out, red_out, green_out, blue_out,
               hpos_out, vpos_out, line_start, frame_start
    );

    // Consumer side (pins, DAC, future framebuffer readout)
    modport slave (
        output en, mode,
        input  hsync_out, vsync_out, blank_out, red_out, green_out, blue_out,
               hpos_out, vpos_out, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing and test-pattern generator. Single clock domain:
// vcnt steps on the horizontal wrap; every output is registered one cycle behind hcnt/vcnt.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE      = 800,
    parameter int unsigned H_FP          = 56,
    parameter int unsigned H_SYNC        = 120,
    parameter int unsigned H_BP          = 64,
    parameter int unsigned V_ACTIVE      = 600,
    parameter int unsigned V_FP          = 37,
    parameter int unsigned V_SYNC        = 6,
    parameter int unsigned V_BP          = 23,
    parameter int unsigned HS_ACTIVE_LOW = 1,
    parameter int unsigned VS_ACTIVE_LOW = 1,
    parameter int unsigned CW            = 11,
    parameter int unsigned CB            = 1,
    parameter int unsigned CK_SHIFT      = 5,
    parameter int unsigned RAMP_SHIFT    = 4
) (
    input logic              clk50,
    input logic              rst_n,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam bit          HS_IDLE  = (HS_ACTIVE_LOW != 0);
    localparam bit          VS_IDLE  = (VS_ACTIVE_LOW != 0);

    logic [CW-1:0] hcnt, vcnt;
    logic [1:0]    mode_r;
    logic [1:0]    mode_cur;
    logic          h_last, v_last, first_px;
    logic          hs_lvl, vs_lvl, blank;
    logic          bar_r, bar_g, bar_b, ck;
    logic [CB-1:0] pix_r, pix_g, pix_b;

    // Raster position decode and sync/blank levels for the current counter values
    always_comb begin
        h_last   = (hcnt == CW'(H_TOTAL - 1));
        v_last   = (vcnt == CW'(V_TOTAL - 1));
        first_px = (hcnt == '0) && (vcnt == '0);
        // A newly captured mode already governs pixel (0,0) of the frame
        mode_cur = (vga.en && first_px) ? vga.mode : mode_r;
        hs_lvl   = ((hcnt >= CW'(HS_START)) && (hcnt < CW'(HS_END))) ^ HS_IDLE;
        vs_lvl   = ((vcnt >= CW'(VS_START)) && (vcnt < CW'(VS_END))) ^ VS_IDLE;
        blank    = (hcnt >= CW'(H_ACTIVE)) || (vcnt >= CW'(V_ACTIVE));
    end

    // Test-pattern colour, forced to black outside the active area
    always_comb begin
        bar_r = ((hcnt >> 8) & CW'(1)) != '0;
        bar_g = ((hcnt >> 7) & CW'(1)) != '0;
        bar_b = ((hcnt >> 6) & CW'(1)) != '0;
        ck    = (((hcnt ^ vcnt) >> CK_SHIFT) & CW'(1)) != '0;
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        unique case (mode_cur)
            2'd0: ;
            2'd1: begin
                pix_r = {CB{bar_r}};
                pix_g = {CB{bar_g}};
                pix_b = {CB{bar_b}};
            end
            2'd2: begin
                pix_r = {CB{ck}};
                pix_g = {CB{ck}};
                pix_b = {CB{ck}};
            end
            2'd3: begin
                pix_r = CB'(hcnt >> RAMP_SHIFT);
                pix_g = CB'(hcnt >> RAMP_SHIFT);
                pix_b = CB'(hcnt >> RAMP_SHIFT);
            end
            default: ;
        endcase
        if (blank) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    // Raster counters and frame-aligned mode capture
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= '0;
            vcnt   <= '0;
            mode_r <= 2'd0;
        end else if (vga.en) begin
            if (first_px) begin
                mode_r <= vga.mode;
            end
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + CW'(1);
            end else begin
                hcnt <= hcnt + CW'(1);
            end
        end
    end

    // Output registers: hold on en=0, strobes only on enabled cycles
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            vga.hsync_out   <= HS_IDLE;
            vga.vsync_out   <= VS_IDLE;
            vga.blank_out   <= 1'b1;
            vga.red_out     <= '0;
            vga.green_out   <= '0;
            vga.blue_out    <= '0;
            vga.hpos_out    <= '0;
            vga.vpos_out    <= '0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.line_start  <= vga.en && (hcnt == '0);
            vga.frame_start <= vga.en && first_px;
            if (vga.en) begin
                vga.hsync_out <= hs_lvl;
                vga.vsync_out <= vs_lvl;
                vga.blank_out <= blank;
                vga.red_out   <= pix_r;
                vga.green_out <= pix_g;
                vga.blue_out  <= pix_b;
                vga.hpos_out  <= hcnt;
                vga.vpos_out  <= vcnt;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing (A, legacy bars), inverted hsync polarity with
// 4-bit ramp (B), and a tiny raster (C) small enough to cover whole frames.
module tb_vga_timing_gen;
    logic clk50 = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk50 = ~clk50;

    vga_timing_gen_if #(.CW(11), .CB(1)) ia ();
    vga_timing_gen_if #(.CW(11), .CB(4)) ib ();
    vga_timing_gen_if #(.CW(9),  .CB(2)) ic ();

    vga_timing_gen #(.CW(11), .CB(1)) dut_a (
        .clk50 (clk50),
        .rst_n (rst_n),
        .vga   (ia)
    );

    vga_timing_gen #(.HS_ACTIVE_LOW(0), .CW(11), .CB(4)) dut_b (
        .clk50 (clk50),
        .rst_n (rst_n),
        .vga   (ib)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(0),
        .CW(9), .CB(2), .CK_SHIFT(2), .RAMP_SHIFT(1)
    ) dut_c (
        .clk50 (clk50),
        .rst_n (rst_n),
        .vga   (ic)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @%0d: observed %0h expected %0h", tag, idx, obs, exp);
    endtask

    initial begin
        int unsigned h, v, hc, vc, idx;
        int unsigned c_sel, c_eff, c00, exp_c;
        int          a_lines, c_frames;
        bit          bl;

        // Reset held with en=1
        rst_n   = 1'b0;
        ia.en   = 1'b1; ia.mode = 2'd1;
        ib.en   = 1'b1; ib.mode = 2'd3;
        ic.en   = 1'b1; ic.mode = 2'd0;
        c_sel   = 0;
        c_eff   = 0;
        c00     = 0;
        repeat (5) @(posedge clk50);
        @(negedge clk50);
        chk("rst_a_hsync", 0, ia.hsync_out, 1);
        chk("rst_a_vsync", 0, ia.vsync_out, 1);
        chk("rst_a_blank", 0, ia.blank_out, 1);
        chk("rst_a_red",   0, ia.red_out, 0);
        chk("rst_a_green", 0, ia.green_out, 0);
        chk("rst_a_blue",  0, ia.blue_out, 0);
        chk("rst_a_hpos",  0, ia.hpos_out, 0);
        chk("rst_a_vpos",  0, ia.vpos_out, 0);
        chk("rst_a_line",  0, ia.line_start, 0);
        chk("rst_a_frame", 0, ia.frame_start, 0);
        chk("rst_b_hsync", 0, ib.hsync_out, 0);
        chk("rst_b_red",   0, ib.red_out, 0);
        chk("rst_c_vsync", 0, ic.vsync_out, 0);

        // Free-running two lines of A/B, a bit over six frames of C
        rst_n    = 1'b1;
        a_lines  = 0;
        c_frames = 0;
        for (int k = 0; k < 2080; k++) begin
            @(posedge clk50);
            @(negedge clk50);
            idx = k;
            h   = idx % 1040;
            v   = idx / 1040;
            bl  = (h >= 800);
            chk("a_hpos",  k, ia.hpos_out, h);
            chk("a_vpos",  k, ia.vpos_out, v);
            chk("a_hsync", k, ia.hsync_out, !(h >= 856 && h <= 975));
            chk("a_vsync", k, ia.vsync_out, 1);
            chk("a_blank", k, ia.blank_out, bl);
            chk("a_line",  k, ia.line_start, h == 0);
            chk("a_frame", k, ia.frame_start, k == 0);
            chk("a_red",   k, ia.red_out,   bl ? 0 : (h >> 8) & 1);
            chk("a_green", k, ia.green_out, bl ? 0 : (h >> 7) & 1);
            chk("a_blue",  k, ia.blue_out,  bl ? 0 : (h >> 6) & 1);
            if (ia.line_start) a_lines++;

            chk("b_hsync", k, ib.hsync_out, (h >= 856 && h <= 975));
            chk("b_red",   k, ib.red_out,   bl ? 0 : (h >> 4) & 15);
            chk("b_green", k, ib.green_out, bl ? 0 : (h >> 4) & 15);
            chk("b_blue",  k, ib.blue_out,  bl ? 0 : (h >> 4) & 15);
            if (h == 32'h35) chk("b_rgb_at_35", k, ib.red_out, 3);
            if (h == 900)    chk("b_rgb_blank", k, ib.red_out, 0);

            hc = idx % 24;
            vc = (idx / 24) % 14;
            if (hc == 0 && vc == 0) c_eff = c_sel;
            bl = (hc >= 16) || (vc >= 8);
            if (bl || c_eff == 0) exp_c = 0;
            else exp_c = (((hc >> 2) ^ (vc >> 2)) & 1) != 0 ? 3 : 0;
            chk("c_hpos",  k, ic.hpos_out, hc);
            chk("c_vpos",  k, ic.vpos_out, vc);
            chk("c_hsync", k, ic.hsync_out, !(hc >= 18 && hc <= 20));
            chk("c_vsync", k, ic.vsync_out, (vc >= 10 && vc <= 11));
            chk("c_blank", k, ic.blank_out, bl);
            chk("c_line",  k, ic.line_start, hc == 0);
            chk("c_frame", k, ic.frame_start, hc == 0 && vc == 0);
            chk("c_red",   k, ic.red_out, exp_c);
            chk("c_green", k, ic.green_out, exp_c);
            chk("c_blue",  k, ic.blue_out, exp_c);
            if (ic.frame_start) c_frames++;
            if (idx == 336) c00 = ic.red_out;
            if (idx == 340) chk("c_ck_differs", k, ic.red_out != c00[1:0], 1);

            // Switch C to checkerboard mid-frame; takes effect at the next frame
            if (idx == 96) c_sel = 2;
            ic.mode = c_sel[1:0];
        end
        chk("a_line_count",  0, a_lines, 2);
        chk("c_frame_count", 0, c_frames, 7);

        // Asynchronous reset mid-line, away from any clock edge
        repeat (10) @(posedge clk50);
        @(negedge clk50);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_a_hpos",  0, ia.hpos_out, 0);
        chk("mid_a_vpos",  0, ia.vpos_out, 0);
        chk("mid_a_hsync", 0, ia.hsync_out, 1);
        chk("mid_a_blank", 0, ia.blank_out, 1);
        chk("mid_a_red",   0, ia.red_out, 0);
        chk("mid_a_line",  0, ia.line_start, 0);
        chk("mid_b_hsync", 0, ib.hsync_out, 0);
        chk("mid_c_hsync", 0, ic.hsync_out, 1);
        chk("mid_c_vsync", 0, ic.vsync_out, 0);

        // en gating on A: 1,0,1,0,...
        @(negedge clk50);
        ia.en   = 1'b1;
        rst_n   = 1'b1;
        a_lines = 0;
        for (int j = 0; j <= 4200; j++) begin
            @(posedge clk50);
            @(negedge clk50);
            idx = j / 2;
            h   = idx % 1040;
            v   = idx / 1040;
            chk("g_hpos",  j, ia.hpos_out, h);
            chk("g_vpos",  j, ia.vpos_out, v);
            chk("g_hsync", j, ia.hsync_out, !(h >= 856 && h <= 975));
            chk("g_blank", j, ia.blank_out, h >= 800);
            chk("g_line",  j, ia.line_start, (j % 2 == 0) && h == 0);
            chk("g_frame", j, ia.frame_start, j == 0);
            if (ia.line_start) a_lines++;
            ia.en = ((j + 1) % 2 == 0);
        end
        chk("g_line_count", 0, a_lines, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
